// File: rtl/sample_buffer_ctrl_if.sv
// Sample buffer bus: ADC sample stream, drawer frame pulse,
// BRAM write port and ping-pong bank selects.
interface sample_buffer_ctrl_if #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int ADD_SIZE     = 11
);
  logic signed [SAMPLE_WIDTH-1:0] ADC_OUT;
  logic                           ADC_valid;
  logic                           frame_done;
  logic                           wr_en;
  logic [ADD_SIZE-1:0]            wr_addr;
  logic [SAMPLE_WIDTH-1:0]        wr_data;
  logic                           wr_bank;
  logic                           rd_bank;
  logic                           swap;
  logic                           auto_trig;

  modport master (
    input  ADC_OUT, ADC_valid, frame_done,
    output wr_en, wr_addr, wr_data,
    output wr_bank, rd_bank, swap, auto_trig
  );

  modport slave (
    output ADC_OUT, ADC_valid, frame_done,
    input  wr_en, wr_addr, wr_data,
    input  wr_bank, rd_bank, swap, auto_trig
  );
endinterface

// File: rtl/sample_buffer_ctrl.sv
// Triggered ping-pong capture of ADC samples into a BRAM frame.
// Ports: CLK104MHZ, RST (async high), bus (master: ADC in, BRAM/bank out).
module sample_buffer_ctrl #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int ADD_SIZE     = 11,
  parameter int DEPTH        = 1280,
  parameter int TRIG_LEVEL   = 0,
  parameter int TRIG_EN      = 1,
  parameter int TIMEOUT      = 4096
) (
  input logic                   CLK104MHZ,
  input logic                   RST,
  sample_buffer_ctrl_if.master  bus
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [ADD_SIZE-1:0] LAST =
    ADD_SIZE'(DEPTH - 1);
  localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT);
  localparam logic signed [SAMPLE_WIDTH-1:0] TL =
    SAMPLE_WIDTH'(TRIG_LEVEL);

  typedef enum logic [1:0] {
    ARM, WAIT_TRIG, CAPTURE, FULL
  } state_t;

  state_t                         state_q, state_d;
  logic [ADD_SIZE-1:0]            addr_q, addr_d;
  logic [TCW-1:0]                 tcnt_q, tcnt_d;
  logic signed [SAMPLE_WIDTH-1:0] prev_q, prev_d;
  logic                           pvld_q, pvld_d;
  logic                           rdb_q, rdb_d;
  logic                           swap_q, swap_d;
  logic                           auto_q, auto_d;
  logic                           wen_q, wen_d;
  logic [ADD_SIZE-1:0]            wadr_q, wadr_d;
  logic [SAMPLE_WIDTH-1:0]        wdat_q, wdat_d;

  logic signed [SAMPLE_WIDTH-1:0] cur;
  logic                           trig;
  logic                           tout;

  assign cur  = bus.ADC_OUT;
  assign trig = pvld_q && (prev_q < TL) && (cur >= TL);
  assign tout = tcnt_q >= TMAX;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tcnt_d  = tcnt_q;
    prev_d  = prev_q;
    pvld_d  = pvld_q;
    rdb_d   = rdb_q;
    swap_d  = 1'b0;
    auto_d  = auto_q;
    wen_d   = 1'b0;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    unique case (state_q)
      ARM: begin
        addr_d  = '0;
        tcnt_d  = '0;
        pvld_d  = 1'b0;
        state_d = (TRIG_EN != 0) ? WAIT_TRIG : CAPTURE;
      end
      WAIT_TRIG: begin
        if (bus.ADC_valid) begin
          if (trig || tout) begin
            // A real edge wins over a coincident timeout.
            wen_d   = 1'b1;
            wadr_d  = '0;
            wdat_d  = cur;
            auto_d  = !trig;
            addr_d  = ADD_SIZE'(1);
            state_d = (LAST == '0) ? FULL : CAPTURE;
          end else begin
            prev_d = cur;
            pvld_d = 1'b1;
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end
      CAPTURE: begin
        if (bus.ADC_valid) begin
          wen_d  = 1'b1;
          wadr_d = addr_q;
          wdat_d = cur;
          if (addr_q == LAST) begin
            state_d = FULL;
          end else if (addr_q != '1) begin
            addr_d = addr_q + ADD_SIZE'(1);
          end
        end
      end
      FULL: begin
        if (bus.frame_done) begin
          rdb_d   = ~rdb_q;
          swap_d  = 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge CLK104MHZ or posedge RST) begin
    if (RST) begin
      state_q <= ARM;
      addr_q  <= '0;
      tcnt_q  <= '0;
      prev_q  <= '0;
      pvld_q  <= 1'b0;
      rdb_q   <= 1'b0;
      swap_q  <= 1'b0;
      auto_q  <= 1'b0;
      wen_q   <= 1'b0;
      wadr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tcnt_q  <= tcnt_d;
      prev_q  <= prev_d;
      pvld_q  <= pvld_d;
      rdb_q   <= rdb_d;
      swap_q  <= swap_d;
      auto_q  <= auto_d;
      wen_q   <= wen_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
    end
  end

  assign bus.wr_en     = wen_q;
  assign bus.wr_addr   = wadr_q;
  assign bus.wr_data   = wdat_q;
  assign bus.rd_bank   = rdb_q;
  assign bus.wr_bank   = ~rdb_q;
  assign bus.swap      = swap_q;
  assign bus.auto_trig = auto_q;

endmodule

// File: tb/tb_sample_buffer_ctrl.sv
// Randomised bench for sample_buffer_ctrl against a
// sequence-level capture model (DEPTH=8, TIMEOUT=16).
module tb_sample_buffer_ctrl;

  localparam int W  = 12;
  localparam int AW = 11;
  localparam int DP = 8;
  localparam int TO = 16;
  localparam int TL = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          bank;
  } wr_t;

  logic clk = 1'b0;
  logic RST = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int swap_cnt = 0;
  logic mrd = 1'b0;

  wr_t wq[$];
  wr_t fq[$];

  sample_buffer_ctrl_if #(.SAMPLE_WIDTH(W), .ADD_SIZE(AW)) d();
  sample_buffer_ctrl_if #(.SAMPLE_WIDTH(W), .ADD_SIZE(AW)) f();

  sample_buffer_ctrl #(
    .SAMPLE_WIDTH(W), .ADD_SIZE(AW), .DEPTH(DP),
    .TRIG_LEVEL(TL), .TRIG_EN(1), .TIMEOUT(TO)
  ) u_dut (
    .CLK104MHZ(clk),
    .RST(RST),
    .bus(d)
  );

  sample_buffer_ctrl #(
    .SAMPLE_WIDTH(W), .ADD_SIZE(AW), .DEPTH(DP),
    .TRIG_LEVEL(TL), .TRIG_EN(0), .TIMEOUT(TO)
  ) u_fr (
    .CLK104MHZ(clk),
    .RST(RST),
    .bus(f)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    wr_t w;
    if (d.wr_en === 1'b1) begin
      w.addr = d.wr_addr;
      w.data = d.wr_data;
      w.bank = d.wr_bank;
      wq.push_back(w);
    end
    if (f.wr_en === 1'b1) begin
      w.addr = f.wr_addr;
      w.data = f.wr_data;
      w.bank = f.wr_bank;
      fq.push_back(w);
    end
    if (d.swap === 1'b1) swap_cnt++;
    if (!RST) begin
      vectors++;
      if (d.wr_bank !== ~d.rd_bank) begin
        miscompares++;
        $display("FAIL bank_excl wr=%b rd=%b",
                 d.wr_bank, d.rd_bank);
      end
    end
  end

  // Index of the sample that starts the frame, or -1.
  function automatic int find_start(
    input int q[$], output bit au);
    au = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (i >= 1 && q[i-1] < TL && q[i] >= TL) begin
        au = 1'b0;
        return i;
      end
      if (i >= TO) begin
        au = 1'b1;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input bit fd,
                      input int gap);
    d.ADC_OUT    = W'(s);
    d.ADC_valid  = 1'b1;
    d.frame_done = fd;
    step();
    d.ADC_valid  = 1'b0;
    d.frame_done = 1'b0;
    repeat (gap) step();
  endtask

  task automatic run_capture(input int q[$],
                             input int fd_idx,
                             input string tag);
    int st, n;
    bit au;
    logic [W-1:0] ed;
    wq.delete();
    foreach (q[i])
      send(q[i], i == fd_idx, $urandom_range(0, 2));
    repeat (3) step();
    st = find_start(q, au);
    n = (st < 0) ? 0 : q.size() - st;
    if (n > DP) n = DP;
    vectors++;
    if (wq.size() != n) begin
      miscompares++;
      $display("FAIL %s_count got %0d want %0d",
               tag, wq.size(), n);
    end
    for (int k = 0; k < n && k < wq.size(); k++) begin
      ed = W'(q[st+k]);
      vectors++;
      if (wq[k].addr !== AW'(k) || wq[k].data !== ed ||
          wq[k].bank !== ~mrd) begin
        miscompares++;
        $display("FAIL %s_wr%0d got a=%0d d=%h b=%b want a=%0d d=%h b=%b",
                 tag, k, wq[k].addr, wq[k].data, wq[k].bank,
                 k, ed, ~mrd);
      end
    end
    if (n == DP) begin
      vectors++;
      if (d.auto_trig !== au) begin
        miscompares++;
        $display("FAIL %s_auto got %b want %b",
                 tag, d.auto_trig, au);
      end
    end
  endtask

  task automatic do_swap(input string tag);
    d.frame_done = 1'b1;
    step();
    d.frame_done = 1'b0;
    mrd = ~mrd;
    vectors++;
    if (d.swap !== 1'b1 || d.rd_bank !== mrd ||
        d.wr_bank !== ~mrd) begin
      miscompares++;
      $display("FAIL %s_swap got s=%b rd=%b wr=%b want s=1 rd=%b wr=%b",
               tag, d.swap, d.rd_bank, d.wr_bank, mrd, ~mrd);
    end
    step();
    vectors++;
    if (d.swap !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_swap_len got %b want 0", tag, d.swap);
    end
    repeat (2) step();
  endtask

  task automatic check_reset_vals(input string tag);
    vectors++;
    if (d.rd_bank !== 1'b0 || d.wr_bank !== 1'b1 ||
        d.wr_en !== 1'b0 || d.wr_addr !== '0 ||
        d.wr_data !== '0 || d.swap !== 1'b0 ||
        d.auto_trig !== 1'b0) begin
      miscompares++;
      $display("FAIL %s got rd=%b wr=%b en=%b a=%0d d=%h s=%b at=%b want 0 1 0 0 0 0 0",
               tag, d.rd_bank, d.wr_bank, d.wr_en, d.wr_addr,
               d.wr_data, d.swap, d.auto_trig);
    end
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    repeat (2) step();
    check_reset_vals("reset");
    RST = 1'b0;
    mrd = 1'b0;
    repeat (3) step();
    check_reset_vals("post_reset");
  endtask

  task automatic test_trigger();
    int q[$];
    q = {-5, -1, 3};
    repeat (10) q.push_back($urandom_range(0, 200) - 100);
    run_capture(q, -1, "trig");
  endtask

  task automatic test_swap();
    int q[$];
    do_swap("swap1");
    q = {-20, -7, 9};
    repeat (8) q.push_back($urandom_range(0, 200) - 100);
    run_capture(q, -1, "bank0");
    do_swap("swap2");
  endtask

  task automatic test_random();
    int q[$];
    int len;
    for (int it = 0; it < 5; it++) begin
      q.delete();
      len = $urandom_range(25, 30);
      for (int i = 0; i < len; i++)
        q.push_back($urandom_range(0, 60) - 30);
      run_capture(q, -1, $sformatf("rand%0d", it));
      do_swap($sformatf("rswap%0d", it));
    end
  endtask

  task automatic test_timeout();
    int q[$];
    repeat (26) q.push_back(100);
    run_capture(q, -1, "tmo");
    do_swap("tmo_swap");
  endtask

  task automatic test_coincident();
    int q[$];
    int sc;
    q = {-5, 3};
    for (int i = 0; i < 7; i++) q.push_back(10 + i);
    sc = swap_cnt;
    // Sample index 8 is the addr-7 write (start index 1).
    run_capture(q, 8, "coinc");
    vectors++;
    if (swap_cnt != sc || d.rd_bank !== mrd) begin
      miscompares++;
      $display("FAIL coinc_noswap got swaps=%0d rd=%b want 0 rd=%b",
               swap_cnt - sc, d.rd_bank, mrd);
    end
    do_swap("coinc_swap");
  endtask

  task automatic test_free_run();
    int q[$];
    logic [W-1:0] ed;
    fq.delete();
    repeat (10) q.push_back($urandom_range(0, 200) - 100);
    foreach (q[i]) begin
      f.ADC_OUT   = W'(q[i]);
      f.ADC_valid = 1'b1;
      step();
      f.ADC_valid = 1'b0;
      repeat ($urandom_range(0, 1)) step();
    end
    repeat (3) step();
    vectors++;
    if (fq.size() != DP) begin
      miscompares++;
      $display("FAIL frun_count got %0d want %0d",
               fq.size(), DP);
    end
    for (int k = 0; k < DP && k < fq.size(); k++) begin
      ed = W'(q[k]);
      vectors++;
      if (fq[k].addr !== AW'(k) || fq[k].data !== ed ||
          fq[k].bank !== 1'b1) begin
        miscompares++;
        $display("FAIL frun_wr%0d got a=%0d d=%h b=%b want a=%0d d=%h b=1",
                 k, fq[k].addr, fq[k].data, fq[k].bank, k, ed);
      end
    end
  endtask

  task automatic test_reset_mid();
    int q[$];
    int r[$];
    q = {-5, 3, 10, 20, 30};
    foreach (q[i]) send(q[i], 1'b0, 0);
    vectors++;
    if (d.wr_en !== 1'b1 || d.wr_addr !== AW'(3) ||
        d.wr_data !== W'(30)) begin
      miscompares++;
      $display("FAIL mid_wr3 got en=%b a=%0d d=%h want 1 3 %h",
               d.wr_en, d.wr_addr, d.wr_data, W'(30));
    end
    #2 RST = 1'b1;
    #1 check_reset_vals("mid_reset");
    step();
    RST = 1'b0;
    mrd = 1'b0;
    repeat (3) step();
    r = {-9, 4};
    repeat (9) r.push_back($urandom_range(0, 200) - 100);
    run_capture(r, -1, "after_rst");
  endtask

  initial begin
    d.ADC_OUT    = '0;
    d.ADC_valid  = 1'b0;
    d.frame_done = 1'b0;
    f.ADC_OUT    = '0;
    f.ADC_valid  = 1'b0;
    f.frame_done = 1'b0;
    test_reset();
    test_trigger();
    test_swap();
    test_random();
    test_timeout();
    test_coincident();
    test_free_run();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_buffer_ctrl.md
SAMPLE_BUFFER_CTRL -- requirements
Module: sample_buffer_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12, width of the signed ADC sample.
REQ-002 SHALL have parameter ADD_SIZE, default 11, width of the BRAM address.
REQ-003 SHALL have parameter DEPTH, default 1280, samples per frame (one per active column).
REQ-004 SHALL have parameter TRIG_LEVEL, default 0, signed rising-edge trigger threshold.
REQ-005 SHALL have parameter TRIG_EN, default 1; 0 = free-run, with no trigger search.
REQ-006 SHALL have parameter TIMEOUT, default 4096, accepted samples waited before auto-trigger.
REQ-007 SHALL have port CLK104MHZ, input, 1, sole clock; all logic on the rising edge.
REQ-008 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-009 SHALL have port ADC_OUT, input, SAMPLE_WIDTH, signed sample from the XADC controller.
REQ-010 SHALL have port ADC_valid, input, 1, one-cycle strobe qualifying ADC_OUT.
REQ-011 SHALL have port frame_done, input, 1, one-cycle pulse from the drawer on the last visible pixel.
REQ-012 SHALL have port wr_en, output, 1, BRAM write strobe.
REQ-013 SHALL have port wr_addr, output, ADD_SIZE, BRAM write address.
REQ-014 SHALL have port wr_data, output, SAMPLE_WIDTH, BRAM write data.
REQ-015 SHALL have port wr_bank, output, 1, bank written; always equals ~rd_bank.
REQ-016 SHALL have port rd_bank, output, 1, bank the drawer reads (its activeBRAMselect source).
REQ-017 SHALL have port swap, output, 1, one-cycle pulse in the cycle rd_bank changes.
REQ-018 SHALL have port auto_trig, output, 1, sticky flag: last capture was started by timeout.

Function
REQ-019 SHALL implement the states ARM, WAIT_TRIG, CAPTURE and FULL.
REQ-020 ARM SHALL last one cycle: clear the address counter, the timeout counter and the prev-sample-valid bit, then go to WAIT_TRIG, or to CAPTURE if TRIG_EN=0.
REQ-021 WAIT_TRIG: on each ADC_valid, store the sample as prev and increment the timeout counter.
REQ-022 Trigger SHALL be prev valid AND prev < TRIG_LEVEL AND current >= TRIG_LEVEL, all signed compares; the first sample after ARM SHALL never trigger.
REQ-023 On trigger, the triggering sample SHALL be written at address 0 and the state goes to CAPTURE; auto_trig is cleared.
REQ-024 If the timeout counter reaches TIMEOUT without a trigger, the next valid sample SHALL be written at address 0, the state goes to CAPTURE and auto_trig is set.
REQ-025 CAPTURE: each ADC_valid SHALL write the sample at the next address, incrementing by 1.
REQ-026 After the write to address DEPTH-1, the state SHALL go to FULL; there is no address wrap.
REQ-027 FULL: ADC_valid SHALL be ignored (no writes) until frame_done.
REQ-028 frame_done in FULL SHALL toggle rd_bank and wr_bank, pulse swap, and go to ARM.
REQ-029 frame_done in ARM, WAIT_TRIG or CAPTURE SHALL be ignored; the banks are unchanged and the drawer repeats the old frame.
REQ-030 frame_done in the same cycle as the DEPTH-1 write SHALL NOT swap; the swap waits for the next frame_done.
REQ-031 wr_en, wr_addr and wr_data SHALL be registered, asserted in the cycle after the accepting edge, with wr_en high for exactly one cycle per write.
REQ-032 wr_bank SHALL never equal rd_bank, so a write never targets the displayed bank.
REQ-033 Arithmetic: the address counter is ADD_SIZE bits and the timeout counter is clog2(TIMEOUT+1) bits; both saturate and never wrap.

Reset
REQ-034 RST high SHALL force state ARM, rd_bank=0, wr_bank=1, wr_en=0, wr_addr=0, wr_data=0, swap=0, auto_trig=0, and clear the prev sample and counters asynchronously.
REQ-035 RST during CAPTURE SHALL abandon the partial frame; after release, capture restarts from ARM with no write to the displayed bank.

Verification (bench: DEPTH=8, TIMEOUT=16, TRIG_LEVEL=0)
REQ-036 Samples -5,-1,+3,... -> +3 written at bank 1 addr 0; the next 7 samples fill addr 1..7; state FULL; no wr_en for later samples.
REQ-037 FULL, then a frame_done pulse -> swap=1 for one cycle, rd_bank=1, wr_bank=0, the next capture writes bank 0.
REQ-038 Constant +100 samples -> no trigger; the 17th sample is written at addr 0 with auto_trig=1.
REQ-039 frame_done coincident with the addr-7 write -> no swap; the next frame_done swaps.
REQ-040 TRIG_EN=0 -> 8 consecutive samples written at addr 0..7 directly after ARM.
REQ-041 RST asserted after 4 writes -> outputs take their reset values immediately; after release, rd_bank=0 and the first write is to bank 1 addr 0.
